// File: rtl/rep_mux_rr.sv
// rep_mux_rr: packet-level round-robin merge of CH_N multi-lane Avalon-ST channels into one wide stream.
// Build option: define REP_MUX_RR_FILL_EN to replicate the highest accepted lane word into unused output lanes.
module rep_mux_rr #(
  parameter int DATA_W  = 12,
  parameter int LANES   = 2,
  parameter int CH_N    = 4,
  parameter int CH_W    = $clog2(CH_N),
  parameter int EMPTY_W = $clog2(LANES + 1)
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic [CH_N*LANES-1:0][DATA_W-1:0]      snk_data_i,
  input  logic [CH_N*LANES-1:0]                  snk_vd_i,
  input  logic [CH_N*LANES-1:0]                  snk_sop_i,
  input  logic [CH_N*LANES-1:0]                  snk_eop_i,
  output logic [CH_N*LANES-1:0]                  snk_rdy_o,
  output logic [LANES*DATA_W-1:0]                src_data_o,
  output logic                                   src_vd_o,
  output logic                                   src_sop_o,
  output logic                                   src_eop_o,
  output logic [EMPTY_W-1:0]                     src_empty_o,
  output logic [CH_W-1:0]                        src_ch_o,
  input  logic                                   src_rdy_i
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  state_e                         state_r, state_nxt_s;
  logic [CH_W-1:0]                gnt_ch_r, gnt_ch_nxt_s;
  logic [CH_W-1:0]                rr_ptr_r, rr_ptr_nxt_s;
  logic [CH_N-1:0]                req_s;
  logic                           any_req_s;
  logic                           scan_hit_s;
  int                             scan_idx_s;
  logic [CH_W-1:0]                pick_ch_s;
  logic [LANES-1:0]               sel_vd_s;
  logic [LANES-1:0]               sel_eop_s;
  logic                           sel_sop_s;
  logic [LANES-1:0][DATA_W-1:0]   sel_data_s;
  logic                           slot_free_s;
  logic                           alive_s;
  logic [LANES-1:0]               acc_s;
  logic [EMPTY_W-1:0]             acc_cnt_s;
  logic                           beat_eop_s;
  logic                           accept_s;
  logic [DATA_W-1:0]              fill_word_s;
  logic [LANES*DATA_W-1:0]        beat_data_s;

  assign slot_free_s = ~src_vd_o | src_rdy_i;
  assign accept_s    = acc_s[0];

  // per-channel request taken from lane 0 valid
  always_comb begin
    req_s = '0;
    for (int c = 0; c < CH_N; c++) begin
      req_s[c] = snk_vd_i[c*LANES];
    end
  end

  // round-robin search upward from rr_ptr with wrap
  always_comb begin
    any_req_s  = 1'b0;
    pick_ch_s  = rr_ptr_r;
    scan_idx_s = 0;
    scan_hit_s = 1'b0;
    for (int k = 0; k < CH_N; k++) begin
      scan_idx_s = (int'(rr_ptr_r) + k) % CH_N;
      scan_hit_s = req_s[CH_W'(scan_idx_s)] & ~any_req_s;
      pick_ch_s  = scan_hit_s ? CH_W'(scan_idx_s) : pick_ch_s;
      any_req_s  = any_req_s | req_s[CH_W'(scan_idx_s)];
    end
  end

  // lane view of the granted channel
  always_comb begin
    sel_vd_s   = '0;
    sel_eop_s  = '0;
    sel_sop_s  = 1'b0;
    sel_data_s = '0;
    for (int c = 0; c < CH_N; c++) begin
      for (int l = 0; l < LANES; l++) begin
        sel_vd_s[l]   = sel_vd_s[l]  | (snk_vd_i[c*LANES+l]  & (gnt_ch_r == CH_W'(c)));
        sel_eop_s[l]  = sel_eop_s[l] | (snk_eop_i[c*LANES+l] & (gnt_ch_r == CH_W'(c)));
        sel_data_s[l] = sel_data_s[l] | (snk_data_i[c*LANES+l] & {DATA_W{gnt_ch_r == CH_W'(c)}});
      end
      sel_sop_s = sel_sop_s | (snk_sop_i[c*LANES] & (gnt_ch_r == CH_W'(c)));
    end
  end

  // accepted lanes: contiguous valid prefix, cut after the first eop lane
  always_comb begin
    acc_s       = '0;
    acc_cnt_s   = '0;
    beat_eop_s  = 1'b0;
    beat_data_s = '0;
    fill_word_s = '0;
    alive_s     = (state_r == ST_GRANT) & slot_free_s;
    for (int l = 0; l < LANES; l++) begin
      acc_s[l] = alive_s & sel_vd_s[l];
      if (acc_s[l]) begin
        acc_cnt_s                        = acc_cnt_s + EMPTY_W'(1);
        beat_eop_s                       = sel_eop_s[l];
        beat_data_s[l*DATA_W +: DATA_W]  = sel_data_s[l];
        fill_word_s                      = sel_data_s[l];
      end else begin
`ifdef REP_MUX_RR_FILL_EN
        beat_data_s[l*DATA_W +: DATA_W]  = fill_word_s;
`else
        beat_data_s[l*DATA_W +: DATA_W]  = {DATA_W{1'b0}};
`endif
      end
      alive_s = acc_s[l] & ~sel_eop_s[l];
    end
  end

  // ready only toward the accepted lanes of the granted channel
  always_comb begin
    snk_rdy_o = '0;
    for (int c = 0; c < CH_N; c++) begin
      for (int l = 0; l < LANES; l++) begin
        snk_rdy_o[c*LANES+l] = acc_s[l] & (gnt_ch_r == CH_W'(c));
      end
    end
  end

  // arbitration FSM next state
  always_comb begin
    state_nxt_s  = state_r;
    gnt_ch_nxt_s = gnt_ch_r;
    rr_ptr_nxt_s = rr_ptr_r;
    case (state_r)
      ST_IDLE: begin
        if (any_req_s) begin
          gnt_ch_nxt_s = pick_ch_s;
          state_nxt_s  = ST_GRANT;
        end else begin
          state_nxt_s  = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (accept_s && beat_eop_s) begin
          if (gnt_ch_r == CH_W'(CH_N - 1)) begin
            rr_ptr_nxt_s = '0;
          end else begin
            rr_ptr_nxt_s = gnt_ch_r + CH_W'(1);
          end
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_GRANT;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // state and output beat registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r     <= ST_IDLE;
      gnt_ch_r    <= '0;
      rr_ptr_r    <= '0;
      src_data_o  <= '0;
      src_vd_o    <= 1'b0;
      src_sop_o   <= 1'b0;
      src_eop_o   <= 1'b0;
      src_empty_o <= '0;
      src_ch_o    <= '0;
    end else begin
      state_r  <= state_nxt_s;
      gnt_ch_r <= gnt_ch_nxt_s;
      rr_ptr_r <= rr_ptr_nxt_s;
      if (accept_s) begin
        src_data_o  <= beat_data_s;
        src_vd_o    <= 1'b1;
        src_sop_o   <= sel_sop_s;
        src_eop_o   <= beat_eop_s;
        src_empty_o <= EMPTY_W'(LANES) - acc_cnt_s;
        src_ch_o    <= gnt_ch_r;
      end else if (src_rdy_i) begin
        src_vd_o    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rep_mux_rr.sv
// Self-checking bench for rep_mux_rr (CH_N=4, LANES=2, DATA_W=12): vector table plus directed sequences.
module tb_rep_mux_rr;

  logic                 clk = 1'b0;
  logic                 rst_i;
  logic [7:0][11:0]     snk_data;
  logic [7:0]           snk_vd, snk_sop, snk_eop, snk_rdy;
  logic [23:0]          src_data;
  logic                 src_vd, src_sop, src_eop, src_rdy;
  logic [1:0]           src_empty, src_ch;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rep_mux_rr #(.DATA_W(12), .LANES(2), .CH_N(4)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .snk_data_i(snk_data), .snk_vd_i(snk_vd), .snk_sop_i(snk_sop), .snk_eop_i(snk_eop),
    .snk_rdy_o(snk_rdy),
    .src_data_o(src_data), .src_vd_o(src_vd), .src_sop_o(src_sop), .src_eop_o(src_eop),
    .src_empty_o(src_empty), .src_ch_o(src_ch), .src_rdy_i(src_rdy)
  );

  typedef struct {
    logic        rst;
    int          ch;
    logic [1:0]  vd;
    logic        sop;
    logic [1:0]  eop;
    logic [11:0] d0, d1;
    logic        rdy;
    logic        x_full;
    logic [7:0]  x_rdy;
    logic        x_vd, x_sop, x_eop;
    logic [1:0]  x_empty, x_ch;
    logic [23:0] x_data;
  } row_t;

  row_t rows[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic clear_in();
    snk_data = '0; snk_vd = '0; snk_sop = '0; snk_eop = '0;
  endtask

  task automatic drive_ch(input int c, input logic [1:0] v, input logic s, input logic [1:0] e,
                          input logic [11:0] d0, input logic [11:0] d1);
    snk_vd[c*2]     = v[0];  snk_vd[c*2+1]   = v[1];
    snk_eop[c*2]    = e[0];  snk_eop[c*2+1]  = e[1];
    snk_sop[c*2]    = s;
    snk_data[c*2]   = d0;    snk_data[c*2+1] = d1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_i = 1'b1; src_rdy = 1'b1; clear_in();
    @(negedge clk);
  endtask

  function automatic logic [11:0] mk(input int c, input int b, input int l);
    return 12'(c*256 + b*16 + l);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int beat_c[4];
    int obeat, last_sop, exp_c, eb, beat, nrx;
    logic [24:0] hold;

    rst_i = 1'b1; src_rdy = 1'b1; clear_in();

    // rst ch vd sop eop d0 d1 rdy | full x_rdy x_vd sop eop empty ch data
    rows[0]  = '{1'b0, 0, 2'b00, 1'b0, 2'b00, 12'h000, 12'h000, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 24'h000000};
    rows[1]  = '{1'b0, 2, 2'b11, 1'b1, 2'b00, 12'h001, 12'h002, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 24'h000000};
    rows[2]  = '{1'b0, 2, 2'b11, 1'b1, 2'b00, 12'h001, 12'h002, 1'b1, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 24'h000000};
    rows[3]  = '{1'b0, 2, 2'b11, 1'b0, 2'b00, 12'h003, 12'h004, 1'b1, 1'b0, 8'h30, 1'b1, 1'b1, 1'b0, 2'd0, 2'd2, 24'h002001};
    rows[4]  = '{1'b0, 2, 2'b11, 1'b0, 2'b10, 12'h005, 12'h006, 1'b1, 1'b0, 8'h30, 1'b1, 1'b0, 1'b0, 2'd0, 2'd2, 24'h004003};
    rows[5]  = '{1'b0, 0, 2'b00, 1'b0, 2'b00, 12'h000, 12'h000, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 2'd0, 2'd2, 24'h006005};
    rows[6]  = '{1'b0, 0, 2'b00, 1'b0, 2'b00, 12'h000, 12'h000, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 24'h000000};
    rows[7]  = '{1'b0, 1, 2'b11, 1'b1, 2'b01, 12'h0AB, 12'h0CD, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 24'h000000};
    rows[8]  = '{1'b0, 1, 2'b11, 1'b1, 2'b01, 12'h0AB, 12'h0CD, 1'b1, 1'b0, 8'h04, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 24'h000000};
`ifdef REP_MUX_RR_FILL_EN
    rows[9]  = '{1'b0, 1, 2'b10, 1'b0, 2'b00, 12'h000, 12'h0CD, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 2'd1, 2'd1, 24'h0AB0AB};
`else
    rows[9]  = '{1'b0, 1, 2'b10, 1'b0, 2'b00, 12'h000, 12'h0CD, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 2'd1, 2'd1, 24'h0000AB};
`endif
    rows[10] = '{1'b0, 0, 2'b10, 1'b1, 2'b00, 12'h000, 12'h0EE, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 24'h000000};
    rows[11] = '{1'b0, 0, 2'b10, 1'b1, 2'b00, 12'h000, 12'h0EE, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 24'h000000};
    rows[12] = '{1'b0, 0, 2'b10, 1'b1, 2'b00, 12'h000, 12'h0EE, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 24'h000000};

    // table: single channel, unaligned eop, non-contiguous valid
    do_reset();
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      clear_in();
      rst_i   = rows[i].rst;
      src_rdy = rows[i].rdy;
      drive_ch(rows[i].ch, rows[i].vd, rows[i].sop, rows[i].eop, rows[i].d0, rows[i].d1);
      #1;
      chk($sformatf("row%0d_snk_rdy", i), 64'(snk_rdy), 64'(rows[i].x_rdy));
      chk($sformatf("row%0d_src_vd", i), 64'(src_vd), 64'(rows[i].x_vd));
      if (rows[i].x_vd || rows[i].x_full) begin
        chk($sformatf("row%0d_src_beat", i), {31'd0, src_sop, src_eop, src_empty, src_ch, src_data},
            {31'd0, rows[i].x_sop, rows[i].x_eop, rows[i].x_empty, rows[i].x_ch, rows[i].x_data});
      end
    end

    // round robin: all channels stream 2-beat packets
    do_reset();
    for (int c = 0; c < 4; c++) beat_c[c] = 0;
    obeat = 0; last_sop = 0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      @(negedge clk);
      rst_i = 1'b0; src_rdy = 1'b1; clear_in();
      for (int c = 0; c < 4; c++) begin
        drive_ch(c, 2'b11, beat_c[c] == 0, (beat_c[c] == 1) ? 2'b10 : 2'b00,
                 mk(c, beat_c[c], 0), mk(c, beat_c[c], 1));
      end
      #1;
      if (src_vd && obeat < 10) begin
        exp_c = (obeat / 2) % 4;
        eb    = obeat % 2;
        chk($sformatf("rr_beat%0d_ch", obeat), 64'(src_ch), 64'(exp_c));
        chk($sformatf("rr_beat%0d_data", obeat), 64'(src_data), {40'd0, mk(exp_c, eb, 1), mk(exp_c, eb, 0)});
        chk($sformatf("rr_beat%0d_flags", obeat), {62'd0, src_sop, src_eop}, {62'd0, eb == 0, eb == 1});
        if (eb == 0 && obeat > 0) chk($sformatf("rr_gap%0d", obeat), 64'(cyc - last_sop), 64'd3);
        if (eb == 0) last_sop = cyc;
        obeat++;
      end
      for (int c = 0; c < 4; c++) begin
        if (snk_rdy[c*2]) beat_c[c] = (beat_c[c] + 1) % 2;
      end
    end
    chk("rr_beat_count", 64'(obeat), 64'd10);

    // backpressure: ch2 4-beat packet, downstream stalls 5 cycles
    do_reset();
    beat = 0; nrx = 0; hold = '0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      @(negedge clk);
      rst_i = 1'b0; clear_in();
      src_rdy = !(cyc >= 4 && cyc <= 8);
      if (beat < 4) drive_ch(2, 2'b11, beat == 0, (beat == 3) ? 2'b10 : 2'b00, 12'(beat*2+1), 12'(beat*2+2));
      #1;
      if (cyc == 4) hold = {src_vd, src_data};
      if (cyc >= 4 && cyc <= 8) chk($sformatf("bp_rdy_c%0d", cyc), 64'(snk_rdy), 64'd0);
      if (cyc >= 5 && cyc <= 8) chk($sformatf("bp_hold_c%0d", cyc), 64'({src_vd, src_data}), 64'(hold));
      if (src_vd && src_rdy) begin
        chk($sformatf("bp_rx%0d_data", nrx), 64'(src_data), {40'd0, 12'(nrx*2+2), 12'(nrx*2+1)});
        chk($sformatf("bp_rx%0d_eop", nrx), 64'(src_eop), 64'(nrx == 3));
        nrx++;
      end
      if (snk_rdy[4]) beat++;
    end
    chk("bp_rx_count", 64'(nrx), 64'd4);

    // reset mid-packet of ch3 (rr_ptr is 3 here), then ch0 and ch3 compete
    beat = 0;
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk);
      clear_in(); src_rdy = 1'b1;
      rst_i = (cyc == 2);
      drive_ch(3, 2'b11, beat == 0, (beat == 2) ? 2'b10 : 2'b00, 12'h300 + 12'(beat), 12'h310 + 12'(beat));
      #1;
      if (cyc == 1) chk("rst_pre_grant_ch3", 64'(snk_rdy), 64'hC0);
      if (snk_rdy[6]) beat++;
    end
    @(negedge clk);
    rst_i = 1'b0; clear_in();
    drive_ch(0, 2'b11, 1'b1, 2'b10, 12'h00A, 12'h00B);
    drive_ch(3, 2'b11, 1'b1, 2'b10, 12'h300, 12'h310);
    #1;
    chk("rst_outputs_zero", {36'd0, src_vd, src_sop, src_eop, src_empty, src_ch, src_data}, 64'd0);
    chk("rst_snk_rdy_idle", 64'(snk_rdy), 64'd0);
    @(negedge clk);
    #1;
    chk("rst_then_grant_ch0", 64'(snk_rdy), 64'h03);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rep_mux_rr.md
# rep_mux_rr

Parametrised packet multiplexer that merges CH_N Avalon-ST channels, each LANES words wide, into one output stream of LANES×DATA_W bits. Arbitration is packet-level round-robin: once granted, a channel holds the output from its first beat until its eop beat. Unaligned last beats (fewer valid lanes) are supported and reported via an empty count. The block sits between the per-channel framers and the wide output link, and adds downstream backpressure.

## Interface
- DATA_W, 12, width of one lane word
- LANES, 2, lanes per channel and per output beat (≥1)
- CH_N, 4, number of input channels (≥2)
- CH_W, $clog2(CH_N), channel index width (derived)
- EMPTY_W, $clog2(LANES+1), empty-count width (derived)

- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  synchronous, active-high reset
- snk_data_i  in  [CH_N*LANES][DATA_W]  lane word; index ch*LANES+l
- snk_vd_i  in  CH_N*LANES  lane valid
- snk_sop_i  in  CH_N*LANES  start of packet (meaningful on lane 0)
- snk_eop_i  in  CH_N*LANES  end of packet on that lane
- snk_rdy_o  out  CH_N*LANES  lane accepted this cycle
- src_data_o  out  LANES*DATA_W  output beat; lane l at bits [l*DATA_W +: DATA_W]
- src_vd_o  out  1  output beat valid
- src_sop_o  out  1  first beat of packet
- src_eop_o  out  1  last beat of packet
- src_empty_o  out  EMPTY_W  unused upper lanes in this beat (0 unless eop beat)
- src_ch_o  out  CH_W  source channel of the beat
- src_rdy_i  in  1  downstream ready

## Operation
- Request of channel c: snk_vd_i[c*LANES].
- States: IDLE, GRANT. Registers: state, gnt_ch, rr_ptr.
- IDLE: if any request, gnt_ch ← first requesting channel searching upward from rr_ptr with wrap; → GRANT. Otherwise stay.
- GRANT: beat of gnt_ch accepted when slot free (!src_vd_o || src_rdy_i) and lane 0 valid.
- Accepted lane set: contiguous prefix of valid lanes from lane 0, truncated after the first lane carrying eop. Lanes outside the set get snk_rdy_o=0. Other channels' snk_rdy_o=0 always.
- snk_rdy_o is combinational from inputs and state.
- Beat eop = eop on the last accepted lane. On an accepted eop beat: rr_ptr ← (gnt_ch+1) mod CH_N; → IDLE.
- src_sop_o = snk_sop_i of lane 0. It is passed through, not used for control.
- src_empty_o = LANES − accepted lane count.
- Unaccepted output lanes are zero (see Configuration).
- GRANT with no request: stay in GRANT and wait. A packet is never split.

## Timing
- Reset values: state=IDLE, rr_ptr=0, gnt_ch=0, all src_* outputs 0, snk_rdy_o=0.
- One idle cycle IDLE→GRANT before each packet. First beat is accepted the cycle after the request is seen.
- Latency: accepted beat appears on src_* on the next rising edge.
- src_vd_o and the src_* payload are held stable while src_vd_o=1 and src_rdy_i=0.
- Accept and drain in the same cycle (src_vd_o=1, src_rdy_i=1, new beat accepted): src_* is replaced with no bubble.
- Sustained throughput is 1 beat/cycle within a packet. There is 1 bubble cycle between packets.
- Reset mid-packet: all state clears next edge and the output beat is dropped. The upstream must restart its packet.
- rr_ptr wraps CH_N−1 → 0.

## Configuration
- REP_MUX_RR_FILL_EN defined: unaccepted output lanes replicate the highest accepted lane word (legacy replicate behaviour for downstream consumers that ignore empty).
- Not defined: unaccepted output lanes are driven to 0.
- src_empty_o is identical in both builds.

## Test plan
- Single channel, CH_N=4, LANES=2: ch2 sends 3 beats (0x001/0x002, 0x003/0x004, 0x005/0x006 with eop on lane 1) → 3 output beats, src_ch_o=2, sop on beat 1, eop on beat 3, empty=0, latency 1 cycle from accept.
- Round-robin: all 4 channels request continuously with 2-beat packets after reset → grant order 0,1,2,3,0, with one idle cycle between packets.
- Unaligned eop: ch1 lane0 0x0AB with eop, lane1 valid 0x0CD → only lane0 ready. Output lane1=0 (0x0AB with FILL_EN), empty=1. The lane1 word is not consumed.
- Backpressure: src_rdy_i low 5 cycles mid-packet → src_* stable, snk_rdy_o=0 throughout. On release, resumes with no lost or duplicated beat.
- Reset mid-packet: rst_i high 1 cycle during beat 2 of ch3 → next cycle all outputs 0, state IDLE, rr_ptr=0. The next request from ch0 and ch3 grants ch0.
- Non-contiguous valid: lane0 idle, lane1 valid on ch0 → no grant, snk_rdy_o=0, src_vd_o stays 0.
